// File: rtl/wb_irq_ctrl_pkg.sv
// Shared constants for the Wishbone interrupt controller:
// register offsets, claim-id width and a byte-select expander.
package wb_irq_ctrl_pkg;

  localparam int ID_W = 5;

  localparam logic [7:0] IRQ_PENDING = 8'h00;
  localparam logic [7:0] IRQ_ENABLE  = 8'h04;
  localparam logic [7:0] IRQ_EDGE    = 8'h08;
  localparam logic [7:0] IRQ_CLAIM   = 8'h0C;

  function automatic logic [31:0] sel_mask(input logic [3:0] sel);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) begin
      m[b*8 +: 8] = {8{sel[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/wb_irq_ctrl_if.sv
// Wishbone classic bus bundle between the core-side master
// and the interrupt controller slave.
interface wb_irq_ctrl_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int SW = 4
);
  logic [AW-1:0] wb_addr_i;
  logic [DW-1:0] wb_data_i;
  logic          wb_we_i;
  logic [SW-1:0] wb_sel_i;
  logic          wb_stb_i;
  logic          wb_cyc_i;
  logic          wb_ack_o;
  logic [DW-1:0] wb_data_o;

  modport master (
    output wb_addr_i, wb_data_i, wb_we_i,
    output wb_sel_i, wb_stb_i, wb_cyc_i,
    input  wb_ack_o, wb_data_o
  );

  modport slave (
    input  wb_addr_i, wb_data_i, wb_we_i,
    input  wb_sel_i, wb_stb_i, wb_cyc_i,
    output wb_ack_o, wb_data_o
  );
endinterface

// File: rtl/wb_irq_ctrl_prio_enc.sv
// Lowest-index-wins encoder: returns index+1 of the
// first set bit, or 0 when the vector is empty.
module irq_prio_enc
  import wb_irq_ctrl_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]    i_vec,
  output logic [ID_W-1:0] o_id
);

  always_comb begin
    o_id = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) o_id = ID_W'(i + 1);
    end
  end

endmodule

// File: rtl/wb_irq_ctrl.sv
// Wishbone interrupt controller: level/edge pending latch,
// per-source enable, claim/complete and one core IRQ line.
module wb_irq_ctrl
  import wb_irq_ctrl_pkg::*;
#(
  parameter int WB_DATA_WIDTH = 32,
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_SEL_WIDTH  = 4,
  parameter int NUM_IRQ       = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  wb_irq_ctrl_if.slave       wb,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic               ext_irq_o
);

  logic [NUM_IRQ-1:0] r_enable;
  logic [NUM_IRQ-1:0] r_edge;
  logic [NUM_IRQ-1:0] r_epend;
  logic [NUM_IRQ-1:0] r_insvc;
  logic [NUM_IRQ-1:0] r_q;
  logic [NUM_IRQ-1:0] r_qq;
  logic               r_ack;
  logic [31:0]        r_rdata;
  logic               r_ext;

  logic [WB_ADDR_WIDTH-1:0] w_addr_full;
  logic [WB_DATA_WIDTH-1:0] w_wdata;
  logic [WB_SEL_WIDTH-1:0]  w_sel;
  logic [7:0]         w_addr;
  logic               w_req;
  logic               w_wr;
  logic               w_rd;
  logic [31:0]        w_bmask;
  logic [NUM_IRQ-1:0] w_mask;
  logic [NUM_IRQ-1:0] w_wd;
  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_pend;
  logic [NUM_IRQ-1:0] w_cand;
  logic [ID_W-1:0]    w_id;
  logic [NUM_IRQ-1:0] w_claim_oh;
  logic [NUM_IRQ-1:0] w_cmpl_oh;
  logic [NUM_IRQ-1:0] w_w1c;
  logic [31:0]        w_rdata;
  logic               w_unused;

  assign w_addr_full = wb.wb_addr_i;
  assign w_wdata     = wb.wb_data_i;
  assign w_sel       = wb.wb_sel_i;
  assign w_addr      = w_addr_full[7:0];
  assign w_unused    = ^{w_addr_full, w_wdata};

  assign w_req   = wb.wb_cyc_i & wb.wb_stb_i & ~r_ack;
  assign w_wr    = w_req & wb.wb_we_i;
  assign w_rd    = w_req & ~wb.wb_we_i;
  assign w_bmask = sel_mask(w_sel);
  assign w_mask  = w_bmask[NUM_IRQ-1:0];
  assign w_wd    = w_wdata[NUM_IRQ-1:0];

  // Edge rise is folded in combinationally so edge and level
  // sources share the same two-edge source-to-core latency.
  assign w_rise = r_q & ~r_qq & r_edge;
  assign w_pend = ((r_epend | w_rise) & r_edge)
                | (r_q & ~r_edge);
  assign w_cand = w_pend & r_enable & ~r_insvc;

  irq_prio_enc #(.N(NUM_IRQ)) u_enc (
    .i_vec (w_cand),
    .o_id  (w_id)
  );

  always_comb begin
    w_claim_oh = '0;
    w_cmpl_oh  = '0;
    w_w1c      = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      w_claim_oh[i] = w_rd & (w_addr == IRQ_CLAIM)
                    & (w_id == ID_W'(i + 1));
      w_cmpl_oh[i]  = w_wr & (w_addr == IRQ_CLAIM)
                    & w_sel[0]
                    & (w_wdata[7:0] == 8'(i + 1));
    end
    if (w_wr && w_addr == IRQ_PENDING) begin
      w_w1c = w_wd & w_mask & r_edge;
    end
  end

  always_comb begin
    w_rdata = '0;
    unique case (1'b1)
      (w_addr == IRQ_PENDING): w_rdata[NUM_IRQ-1:0] = w_pend;
      (w_addr == IRQ_ENABLE):  w_rdata[NUM_IRQ-1:0] = r_enable;
      (w_addr == IRQ_EDGE):    w_rdata[NUM_IRQ-1:0] = r_edge;
      (w_addr == IRQ_CLAIM):   w_rdata[ID_W-1:0]    = w_id;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_enable <= '0;
      r_edge   <= '0;
      r_epend  <= '0;
      r_insvc  <= '0;
      r_q      <= '0;
      r_qq     <= '0;
      r_ack    <= 1'b0;
      r_rdata  <= '0;
      r_ext    <= 1'b0;
    end else begin
      r_q   <= irq_i;
      r_qq  <= r_q;
      r_ack <= w_req;
      r_ext <= |w_cand;
      if (w_rd) r_rdata <= w_rdata;
      if (w_wr && w_addr == IRQ_ENABLE) begin
        r_enable <= (r_enable & ~w_mask) | (w_wd & w_mask);
      end
      if (w_wr && w_addr == IRQ_EDGE) begin
        r_edge <= (r_edge & ~w_mask) | (w_wd & w_mask);
      end
      // A rise on the clearing cycle wins over the clear.
      r_epend <= ((r_epend & ~(w_w1c | w_claim_oh)) | w_rise)
               & r_edge;
      r_insvc <= (r_insvc | w_claim_oh) & ~w_cmpl_oh;
    end
  end

  assign wb.wb_ack_o  = r_ack;
  assign wb.wb_data_o = r_rdata;
  assign ext_irq_o    = r_ext;

endmodule

// File: tb/tb_wb_irq_ctrl.sv
// Scoreboard bench for wb_irq_ctrl: bus tasks queue expected
// read data, a negedge monitor pops and compares on each ack.
module tb_wb_irq_ctrl;
  import wb_irq_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] irq = '0;
  logic       ext;

  wb_irq_ctrl_if bus ();

  wb_irq_ctrl dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .wb        (bus.slave),
    .irq_i     (irq),
    .ext_irq_o (ext)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h",
                  nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (bus.wb_ack_o === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_ack: got ack expected none");
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.rd) check(e.name, bus.wb_data_o, e.exp);
      end
    end
  end

  task automatic xfer(input logic we, input logic [7:0] a,
                      input logic [31:0] d, input logic [3:0] sel,
                      input string nm, input logic [31:0] exp);
    exp_t e;
    logic got;
    e.rd = !we; e.exp = exp; e.name = nm;
    sb.push_back(e);
    @(negedge clk);
    bus.wb_addr_i = {24'h0, a};
    bus.wb_data_i = d;
    bus.wb_we_i   = we;
    bus.wb_sel_i  = sel;
    bus.wb_cyc_i  = 1'b1;
    bus.wb_stb_i  = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      got = bus.wb_ack_o;
    end
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    if (!got) begin
      checks++;
      $display("FAIL %s_ack_timeout: got no ack expected ack", nm);
      void'(sb.pop_back());
    end else begin
      @(posedge clk); #1;
      check({nm, "_ack_width"}, {31'b0, bus.wb_ack_o}, 32'h0);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d,
                    input logic [3:0] sel = 4'hF);
    xfer(1'b1, a, d, sel, "wr", 32'h0);
  endtask

  task automatic rd(input logic [7:0] a, input string nm,
                    input logic [31:0] exp);
    xfer(1'b0, a, 32'h0, 4'hF, nm, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_ext(input string nm, input logic exp);
    check(nm, {31'b0, ext}, {31'b0, exp});
  endtask

  initial begin
    bus.wb_addr_i = '0;
    bus.wb_data_i = '0;
    bus.wb_we_i   = 1'b0;
    bus.wb_sel_i  = '0;
    bus.wb_cyc_i  = 1'b0;
    bus.wb_stb_i  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_ext("rst_ext", 1'b0);
    check("rst_ack", {31'b0, bus.wb_ack_o}, 32'h0);
    @(negedge clk) rst = 1'b0;

    rd(IRQ_PENDING, "rst_pending", 32'h0);
    rd(IRQ_ENABLE,  "rst_enable",  32'h0);
    rd(IRQ_EDGE,    "rst_edge",    32'h0);
    rd(IRQ_CLAIM,   "rst_claim",   32'h0);

    // level source 0
    wr(IRQ_ENABLE, 32'h1);
    @(negedge clk) irq[0] = 1'b1;
    cyc(1); chk_ext("lvl_ext_k", 1'b0);
    cyc(1); chk_ext("lvl_ext_k1", 1'b1);
    rd(IRQ_CLAIM, "lvl_claim", 32'h1);
    chk_ext("lvl_ext_drop", 1'b0);
    wr(IRQ_CLAIM, 32'h1);
    chk_ext("lvl_ext_again", 1'b1);

    // edge source 2
    @(negedge clk) irq = '0;
    wr(IRQ_ENABLE, 32'h4);
    wr(IRQ_EDGE, 32'h4);
    @(negedge clk) irq[2] = 1'b1;
    @(negedge clk) irq[2] = 1'b0;
    cyc(2);
    rd(IRQ_PENDING, "edge_pend", 32'h4);
    rd(IRQ_CLAIM,   "edge_claim", 32'h3);
    rd(IRQ_PENDING, "edge_pend_clr", 32'h0);
    rd(IRQ_CLAIM,   "edge_claim2", 32'h0);
    chk_ext("edge_ext_off", 1'b0);

    // priority among level sources 1,3,5
    wr(IRQ_CLAIM, 32'h3);
    wr(IRQ_EDGE, 32'h0);
    wr(IRQ_ENABLE, 32'hFF);
    @(negedge clk) irq = 8'b0010_1010;
    cyc(2);
    rd(IRQ_CLAIM, "prio_c2", 32'h2);
    rd(IRQ_CLAIM, "prio_c4", 32'h4);
    rd(IRQ_CLAIM, "prio_c6", 32'h6);
    rd(IRQ_CLAIM, "prio_c0", 32'h0);
    wr(IRQ_CLAIM, 32'h4);
    rd(IRQ_CLAIM, "prio_re4", 32'h4);

    // edge source 1, second rise coincident with claim ack
    @(negedge clk) irq = '0;
    wr(IRQ_CLAIM, 32'h2);
    wr(IRQ_CLAIM, 32'h4);
    wr(IRQ_CLAIM, 32'h6);
    wr(IRQ_EDGE, 32'h2);
    wr(IRQ_ENABLE, 32'h2);
    @(negedge clk) irq[1] = 1'b1;
    @(negedge clk) irq[1] = 1'b0;
    cyc(2);
    rd(IRQ_PENDING, "sw_pend", 32'h2);
    @(negedge clk) irq[1] = 1'b1;
    rd(IRQ_CLAIM, "sw_claim", 32'h2);
    irq[1] = 1'b0;
    rd(IRQ_PENDING, "sw_set_wins", 32'h2);
    chk_ext("sw_ext_insvc", 1'b0);

    // ignored completions, byte selects, unmapped offset
    wr(IRQ_CLAIM, 32'h0);
    wr(IRQ_CLAIM, 32'h9);
    rd(IRQ_CLAIM, "cmpl_bad_id", 32'h0);
    wr(IRQ_CLAIM, 32'h2);
    rd(IRQ_CLAIM, "cmpl_ok", 32'h2);
    wr(IRQ_ENABLE, 32'hFFFF_FFFF, 4'b0010);
    rd(IRQ_ENABLE, "sel_byte1", 32'h2);
    wr(IRQ_ENABLE, 32'hFFFF_FF81, 4'b0001);
    rd(IRQ_ENABLE, "sel_byte0", 32'h81);
    wr(IRQ_ENABLE, 32'hFFFF_FFFF);
    rd(IRQ_ENABLE, "enable_width", 32'hFF);
    wr(8'h10, 32'hFFFF_FFFF);
    rd(8'h10, "unmapped", 32'h0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    check("sb_drained", sb.size(), 32'h0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
